// File: rtl/pov_column_sequencer_if.sv
// Column-sequencer bundle: index trigger and enable in, column timing and
// status out. The sequencer side uses the slave modport.
//
// Handshake: col_strobe is a valid-only pulse with no ready. Downstream must
// take col_idx (and frame_start) in the one cycle col_strobe is high. There is
// no backpressure. frame_start only ever rises together with col_strobe.
interface pov_column_sequencer_if #(
  parameter int CNT_W     = 28,
  parameter int COLS_LOG2 = 8
);
  logic                 trigger;
  logic                 enable;
  logic [COLS_LOG2-1:0] col_idx;
  logic                 col_strobe;
  logic                 frame_start;
  logic                 locked;
  logic                 stall;
  logic [CNT_W-1:0]     period_out;
  logic [2:0]           dbg_state;

  modport master (
    output trigger, enable,
    input  col_idx, col_strobe, frame_start, locked, stall, period_out, dbg_state
  );

  modport slave (
    input  trigger, enable,
    output col_idx, col_strobe, frame_start, locked, stall, period_out, dbg_state
  );
endinterface

// File: rtl/pov_column_sequencer.sv
// Speed-tracking POV column sequencer. It measures the rotor period between
// accepted index edges and splits each revolution into 2**COLS_LOG2 equal
// column slots. It issues one strobe plus a column index per slot.
module pov_column_sequencer #(
  parameter int CNT_W        = 28,
  parameter int COLS_LOG2    = 8,
  parameter int MIN_REV_CLKS = 1024,
  parameter int TIMEOUT_CLKS = 2**27
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  pov_column_sequencer_if.slave seq_if
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACQ0  = 3'd1,
    S_ACQ1  = 3'd2,
    S_RUN   = 3'd3,
    S_STALL = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0]     CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]     MIN_CNT     = CNT_W'(MIN_REV_CLKS);
  localparam logic [CNT_W-1:0]     TIMEOUT_CNT = CNT_W'(TIMEOUT_CLKS);
  localparam logic [COLS_LOG2-1:0] LAST_COL    = '1;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, sync3_q, edge_q;
  logic [CNT_W-1:0]     rev_cnt_q, rev_cnt_d;
  logic [CNT_W-1:0]     col_period_q, col_period_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [COLS_LOG2-1:0] col_idx_q, col_idx_d;
  logic                 strobe_q, strobe_d;
  logic                 frame_q, frame_d;
  logic                 seq_on_q, seq_on_d;

  logic                 edge_ok;
  logic                 timeout;
  logic [CNT_W-1:0]     shifted;
  logic [CNT_W-1:0]     new_col_period;

  // Edges count only once the debounce window has elapsed. The exceptions are
  // ACQ0 and STALL, where any edge counts as the first edge of a revolution.
  assign edge_ok = edge_q &&
                   ((state_q == S_ACQ0) || (state_q == S_STALL) || (rev_cnt_q >= MIN_CNT));
  assign timeout = (rev_cnt_q == TIMEOUT_CNT);

  // Truncating division by the column count. Clamp to 1 so the timer never underflows.
  assign shifted        = rev_cnt_q >> COLS_LOG2;
  assign new_col_period = (shifted == '0) ? CNT_ONE : shifted;

  // Next-state, counter and column-engine logic. An accepted edge overrides
  // timer expiry, and enable=0 overrides everything.
  always_comb begin
    state_d      = state_q;
    rev_cnt_d    = (rev_cnt_q == CNT_MAX) ? rev_cnt_q : rev_cnt_q + CNT_ONE;
    col_period_d = col_period_q;
    timer_d      = timer_q;
    period_d     = period_q;
    col_idx_d    = col_idx_q;
    strobe_d     = 1'b0;
    frame_d      = 1'b0;
    seq_on_d     = seq_on_q;

    // Free-running column engine. It stops after the last column is strobed.
    if (seq_on_q) begin
      if (timer_q == '0) begin
        strobe_d  = 1'b1;
        col_idx_d = col_idx_q + COLS_LOG2'(1);
        timer_d   = col_period_q - CNT_ONE;
        seq_on_d  = (col_idx_d != LAST_COL);
      end else begin
        timer_d = timer_q - CNT_ONE;
      end
    end

    case (state_q)
      S_IDLE: begin
        rev_cnt_d = '0;
        if (seq_if.enable) state_d = S_ACQ0;
      end
      S_ACQ0: begin
        // rev_cnt restarts at 1, so it reads the clocks elapsed since the
        // accepted edge. The next edge then latches the exact edge spacing.
        if (edge_ok) begin
          rev_cnt_d = CNT_ONE;
          state_d   = S_ACQ1;
        end
      end
      S_ACQ1, S_RUN: begin
        if (edge_ok) begin
          rev_cnt_d    = CNT_ONE;
          period_d     = rev_cnt_q;
          col_period_d = new_col_period;
          timer_d      = new_col_period - CNT_ONE;
          col_idx_d    = '0;
          strobe_d     = 1'b1;
          frame_d      = 1'b1;
          seq_on_d     = 1'b1;
          state_d      = S_RUN;
        end else if (timeout) begin
          strobe_d = 1'b0;
          seq_on_d = 1'b0;
          state_d  = S_STALL;
        end
      end
      S_STALL: begin
        strobe_d = 1'b0;
        seq_on_d = 1'b0;
        if (edge_ok) begin
          rev_cnt_d = CNT_ONE;
          state_d   = S_ACQ1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!seq_if.enable) begin
      state_d      = S_IDLE;
      rev_cnt_d    = '0;
      col_period_d = '0;
      timer_d      = '0;
      period_d     = '0;
      col_idx_d    = '0;
      strobe_d     = 1'b0;
      frame_d      = 1'b0;
      seq_on_d     = 1'b0;
    end
  end

  // State, synchronizer and datapath registers. Synchronous reset clears all.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      edge_q       <= 1'b0;
      rev_cnt_q    <= '0;
      col_period_q <= '0;
      timer_q      <= '0;
      period_q     <= '0;
      col_idx_q    <= '0;
      strobe_q     <= 1'b0;
      frame_q      <= 1'b0;
      seq_on_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= seq_if.trigger;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      edge_q       <= sync2_q & ~sync3_q;
      rev_cnt_q    <= rev_cnt_d;
      col_period_q <= col_period_d;
      timer_q      <= timer_d;
      period_q     <= period_d;
      col_idx_q    <= col_idx_d;
      strobe_q     <= strobe_d;
      frame_q      <= frame_d;
      seq_on_q     <= seq_on_d;
    end
  end

  assign seq_if.col_idx     = col_idx_q;
  assign seq_if.col_strobe  = strobe_q;
  assign seq_if.frame_start = frame_q;
  assign seq_if.locked      = (state_q == S_RUN);
  assign seq_if.stall       = (state_q == S_STALL);
  assign seq_if.period_out  = period_q;
  assign seq_if.dbg_state   = state_q;

endmodule

// File: tb/tb_pov_column_sequencer.sv
// Bench for pov_column_sequencer. Trigger pulses are planned per segment.
// A revolution-level model turns the planned edge times into expected strobe
// events, which a monitor compares against every strobe the sequencer issues.
module tb_pov_column_sequencer;
  localparam int CNT_W     = 16;
  localparam int COLS_LOG2 = 3;
  localparam int MIN_REV   = 16;
  localparam int TIMEOUT   = 1000;
  localparam int NCOLS     = 8;
  localparam int W         = 41; // {cyc[19:0], idx[2:0], frame, locked, period[15:0]}

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [W-1:0] exp_q[$];
  int           seg_plan[$];
  logic [W-1:0] mon_e, mon_g;

  pov_column_sequencer_if #(.CNT_W(CNT_W), .COLS_LOG2(COLS_LOG2)) seq_if ();

  pov_column_sequencer #(
    .CNT_W(CNT_W), .COLS_LOG2(COLS_LOG2),
    .MIN_REV_CLKS(MIN_REV), .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .seq_if(seq_if)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d limit=50000", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d (cyc %0d)", name, got, exp, cyc);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_col_idx"},     int'(seq_if.col_idx),     0);
    chk({name, "_col_strobe"},  int'(seq_if.col_strobe),  0);
    chk({name, "_frame_start"}, int'(seq_if.frame_start), 0);
    chk({name, "_locked"},      int'(seq_if.locked),      0);
    chk({name, "_stall"},       int'(seq_if.stall),       0);
    chk({name, "_period_out"},  int'(seq_if.period_out),  0);
  endtask

  // ---------------- driver ----------------
  // Each planned pulse p is driven high on negedges p and p+1. It is sampled
  // at edge p+1, so the sequencer acts on it at edge p+4.
  task automatic drive_trig();
    logic t;
    t = 1'b0;
    foreach (seg_plan[i]) if (cyc == seg_plan[i] || cyc == seg_plan[i] + 1) t = 1'b1;
    seq_if.trigger = t;
  endtask

  task automatic run_to(input int stop);
    while (cyc < stop) begin
      @(negedge sys_clk);
      drive_trig();
    end
  endtask

  // ---------------- reference model ----------------
  // Works on whole revolutions. An edge closer than MIN_REV to the last
  // accepted edge is dropped. A gap above TIMEOUT means the rotor stalled,
  // so that edge restarts acquisition. Otherwise the gap is the period, and
  // columns of period/8 clocks follow until the next accepted edge or the
  // end of the segment.
  task automatic model_seg(input int end_edge);
    int acc_t[$];
    int acc_p[$];
    int last;
    bit have;
    int e, gap, cp, lim, s;
    have = 1'b0;
    last = 0;
    seg_plan.sort();
    foreach (seg_plan[i]) begin
      e = seg_plan[i] + 4;
      if (e < end_edge) begin
        if (!have) begin
          have = 1'b1; last = e; acc_t.push_back(e); acc_p.push_back(0);
        end else begin
          gap = e - last;
          if (gap >= MIN_REV) begin
            last = e;
            acc_t.push_back(e);
            acc_p.push_back((gap > TIMEOUT) ? 0 : gap);
          end
        end
      end
    end
    foreach (acc_t[i]) begin
      if (acc_p[i] != 0) begin
        cp  = acc_p[i] / NCOLS;
        if (cp < 1) cp = 1;
        lim = (i + 1 < acc_t.size()) ? acc_t[i+1] : end_edge;
        for (int j = 0; j < NCOLS; j++) begin
          s = acc_t[i] + j * cp;
          if (s < lim)
            exp_q.push_back({20'(s), 3'(j), (j == 0), 1'b1, 16'(acc_p[i])});
        end
      end
    end
  endtask

  // Ends the segment at negedge end_neg. The reset or the enable drop is
  // sampled at the next edge, and all outputs must be 0 right after it.
  task automatic end_seg(input int end_neg, input bit use_rst, input string name);
    run_to(end_neg);
    if (use_rst) rst = 1'b1;
    else seq_if.enable = 1'b0;
    run_to(end_neg + 1);
    chk_zero(name);
    rst = 1'b0;
    seq_if.enable = 1'b0;
    seg_plan.delete();
    run_to(cyc + 10);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge sys_clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0][40:21]) < cyc) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      $display("FAIL strobe_missing exp cyc=%0d idx=%0d fs=%0b per=%0d got none",
               mon_e[40:21], mon_e[20:18], mon_e[17], mon_e[15:0]);
    end
    if (seq_if.col_strobe) begin
      n_checks++;
      mon_g = {20'(cyc), seq_if.col_idx, seq_if.frame_start, seq_if.locked, seq_if.period_out};
      if (exp_q.size() == 0) begin
        $display("FAIL strobe_unexpected got cyc=%0d idx=%0d fs=%0b lk=%0b per=%0d exp none",
                 mon_g[40:21], mon_g[20:18], mon_g[17], mon_g[16], mon_g[15:0]);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_g == mon_e) n_pass++;
        else $display("FAIL strobe got cyc=%0d idx=%0d fs=%0b lk=%0b per=%0d exp cyc=%0d idx=%0d fs=%0b lk=%0b per=%0d",
                      mon_g[40:21], mon_g[20:18], mon_g[17], mon_g[16], mon_g[15:0],
                      mon_e[40:21], mon_e[20:18], mon_e[17], mon_e[16], mon_e[15:0]);
      end
    end else if (seq_if.frame_start) begin
      n_checks++;
      $display("FAIL frame_without_strobe got fs=1 strobe=0 exp fs=0 (cyc %0d)", cyc);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int b, e1, e2, e3, e4, e5, endn, d, gap;
    int offs_a[8];
    int offs_c[6];
    offs_a = '{0, 80, 160, 165, 240, 320, 360, 400};
    offs_c = '{0, 85, 170, 255, 315, 395};
    seq_if.trigger = 1'b0;
    seq_if.enable  = 1'b0;
    rst = 1'b1;
    run_to(3);
    chk_zero("reset");
    rst = 1'b0;
    run_to(8);

    // Segment A: lock at 80, a glitch inside the debounce window, speed-up to
    // 40, then a reset in the middle of a frame.
    seq_if.enable = 1'b1;
    b = cyc + 6;
    foreach (offs_a[i]) seg_plan.push_back(b + offs_a[i]);
    endn = b + 404 + 12;
    model_seg(endn + 1);
    e1 = b + 84;
    run_to(e1 - 1);
    chk("acq1_not_locked", int'(seq_if.locked), 0);
    run_to(e1);
    chk("locked_after_2nd_edge", int'(seq_if.locked), 1);
    chk("period_80", int'(seq_if.period_out), 80);
    run_to(b + 165 + 4 + 2);
    chk("glitch_period_hold", int'(seq_if.period_out), 80);
    run_to(b + 364);
    chk("speedup_period_40", int'(seq_if.period_out), 40);
    run_to(endn);
    chk("locked_before_rst", int'(seq_if.locked), 1);
    end_seg(endn, 1'b1, "rst_mid_run");

    // Segment B: stall after 1000 quiet clocks, then relock on the second edge.
    seq_if.enable = 1'b1;
    b = cyc + 6;
    seg_plan.push_back(b);
    seg_plan.push_back(b + 80);
    seg_plan.push_back(b + 160);
    seg_plan.push_back(b + 1300);
    seg_plan.push_back(b + 1380);
    seg_plan.push_back(b + 1460);
    e2 = b + 164; e3 = b + 1304; e4 = b + 1384; e5 = b + 1464;
    endn = e5 + 40;
    model_seg(endn + 1);
    run_to(e2 + 999);
    chk("no_stall_at_999", int'(seq_if.stall), 0);
    chk("locked_at_999", int'(seq_if.locked), 1);
    run_to(e2 + 1000);
    chk("stall_at_1000", int'(seq_if.stall), 1);
    chk("unlocked_in_stall", int'(seq_if.locked), 0);
    run_to(e3);
    chk("stall_cleared_by_edge", int'(seq_if.stall), 0);
    chk("not_locked_first_edge", int'(seq_if.locked), 0);
    run_to(e4);
    chk("relocked", int'(seq_if.locked), 1);
    end_seg(endn, 1'b0, "enable_off");

    // Segment C: period 85 leaves dead time. A 60-clock gap lands exactly on
    // a timer expiry, and the frame restart must replace that column strobe.
    seq_if.enable = 1'b1;
    b = cyc + 6;
    foreach (offs_c[i]) seg_plan.push_back(b + offs_c[i]);
    endn = b + 399 + 100;
    model_seg(endn + 1);
    run_to(b + 259);
    chk("period_85", int'(seq_if.period_out), 85);
    end_seg(endn, 1'b0, "enable_off_c");

    // Segment D: random spacing, including short glitches and one long gap.
    for (int r = 0; r < 2; r++) begin
      seq_if.enable = 1'b1;
      d = cyc + 6;
      for (int i = 0; i < 30; i++) begin
        seg_plan.push_back(d);
        if (i == 15) gap = $urandom_range(1000, 1100);
        else if ($urandom_range(0, 5) == 0) gap = $urandom_range(6, 20);
        else gap = $urandom_range(20, 160);
        d = d + gap;
      end
      endn = seg_plan[$] + 4 + $urandom_range(1, 120);
      model_seg(endn + 1);
      end_seg(endn, (r == 0), "random_end");
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
